// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// ALU control codes, opcode/funct values and the decode bundle.
package id_ex_stage_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       imm_sel;
        logic       sign_ext;
        logic       wr_en;
        logic       rd_sel;
        logic       illegal;
    } dec_t;

    // A zero destination never counts as a producer.
    function automatic logic fwd_hit(
        input logic       en,
        input logic [4:0] waddr,
        input logic [4:0] src
    );
        return en && (waddr != 5'd0) && (waddr == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode inputs, hazard controls,
// forwarding sources and the registered execute-side outputs.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            in_valid;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [15:0]     imm;
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [4:0]      rd_addr;
    logic            stall;
    logic            flush;
    logic            exm_wr_en;
    logic [4:0]      exm_wr_addr;
    logic [XLEN-1:0] exm_result;
    logic            mwb_wr_en;
    logic [4:0]      mwb_wr_addr;
    logic [XLEN-1:0] mwb_result;

    logic            out_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] store_data;
    logic            illegal;

    modport master (
        output in_valid, opcode, funct, rs_data, rt_data, imm,
        output rs_addr, rt_addr, rd_addr, stall, flush,
        output exm_wr_en, exm_wr_addr, exm_result,
        output mwb_wr_en, mwb_wr_addr, mwb_result,
        input  out_valid, alu_a, alu_b, alu_ctrl,
        input  wr_en, wr_addr, store_data, illegal
    );

    modport slave (
        input  in_valid, opcode, funct, rs_data, rt_data, imm,
        input  rs_addr, rt_addr, rd_addr, stall, flush,
        input  exm_wr_en, exm_wr_addr, exm_result,
        input  mwb_wr_en, mwb_wr_addr, mwb_result,
        output out_valid, alu_a, alu_b, alu_ctrl,
        output wr_en, wr_addr, store_data, illegal
    );

endinterface

// File: rtl/id_ex_stage_alu_decode.sv
// Combinational opcode/funct decoder feeding the ID/EX register.
// Unknown encodings raise illegal with every control cleared.
module alu_decode
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       imm_sel_o,
    output logic       sign_ext_o,
    output logic       wr_en_o,
    output logic       rd_sel_o,
    output logic       illegal_o
);

    dec_t dec;

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (opcode_i == OP_RTYPE): begin
                dec.rd_sel = 1'b1;
                dec.wr_en  = 1'b1;
                unique case (1'b1)
                    (funct_i == FN_AND): dec.alu_ctrl = ALU_AND;
                    (funct_i == FN_OR):  dec.alu_ctrl = ALU_OR;
                    (funct_i == FN_ADD): dec.alu_ctrl = ALU_ADD;
                    (funct_i == FN_XOR): dec.alu_ctrl = ALU_XOR;
                    (funct_i == FN_SUB): dec.alu_ctrl = ALU_SUB;
                    (funct_i == FN_SLT): dec.alu_ctrl = ALU_SLT;
                    default: dec = '{illegal: 1'b1, default: '0};
                endcase
            end
            (opcode_i == OP_ADDI): begin
                dec.alu_ctrl = ALU_ADD;
                dec.imm_sel  = 1'b1;
                dec.sign_ext = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_ANDI): begin
                dec.alu_ctrl = ALU_AND;
                dec.imm_sel  = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_ORI): begin
                dec.alu_ctrl = ALU_OR;
                dec.imm_sel  = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_XORI): begin
                dec.alu_ctrl = ALU_XOR;
                dec.imm_sel  = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_SLTI): begin
                dec.alu_ctrl = ALU_SLT;
                dec.imm_sel  = 1'b1;
                dec.sign_ext = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_LW): begin
                dec.alu_ctrl = ALU_ADD;
                dec.imm_sel  = 1'b1;
                dec.sign_ext = 1'b1;
                dec.wr_en    = 1'b1;
            end
            (opcode_i == OP_SW): begin
                dec.alu_ctrl = ALU_ADD;
                dec.imm_sel  = 1'b1;
                dec.sign_ext = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign alu_ctrl_o = dec.alu_ctrl;
    assign imm_sel_o  = dec.imm_sel;
    assign sign_ext_o = dec.sign_ext;
    assign wr_en_o    = dec.wr_en;
    assign rd_sel_o   = dec.rd_sel;
    assign illegal_o  = dec.illegal;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, optional forwarding and
// stall/flush control. Define ID_EX_FORWARD_EN for bypass muxes.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic [3:0]      dec_ctrl;
    logic            dec_imm_sel;
    logic            dec_sign_ext;
    logic            dec_wr_en;
    logic            dec_rd_sel;
    logic            dec_illegal;

    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      dst;

    logic            valid_q, valid_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] store_q, store_d;

    alu_decode u_dec (
        .opcode_i   (bus.opcode),
        .funct_i    (bus.funct),
        .alu_ctrl_o (dec_ctrl),
        .imm_sel_o  (dec_imm_sel),
        .sign_ext_o (dec_sign_ext),
        .wr_en_o    (dec_wr_en),
        .rd_sel_o   (dec_rd_sel),
        .illegal_o  (dec_illegal)
    );

`ifdef ID_EX_FORWARD_EN
    // The younger EX/MEM result shadows the older MEM/WB one.
    always_comb begin
        rs_val = bus.rs_data;
        if (fwd_hit(bus.exm_wr_en, bus.exm_wr_addr, bus.rs_addr))
            rs_val = bus.exm_result;
        else if (fwd_hit(bus.mwb_wr_en, bus.mwb_wr_addr, bus.rs_addr))
            rs_val = bus.mwb_result;
    end

    always_comb begin
        rt_val = bus.rt_data;
        if (fwd_hit(bus.exm_wr_en, bus.exm_wr_addr, bus.rt_addr))
            rt_val = bus.exm_result;
        else if (fwd_hit(bus.mwb_wr_en, bus.mwb_wr_addr, bus.rt_addr))
            rt_val = bus.mwb_result;
    end
`else
    logic unused_fwd;

    assign rs_val     = bus.rs_data;
    assign rt_val     = bus.rt_data;
    assign unused_fwd = ^{bus.exm_wr_en, bus.exm_wr_addr, bus.exm_result,
                          bus.mwb_wr_en, bus.mwb_wr_addr, bus.mwb_result,
                          bus.rs_addr};
`endif

    assign imm_ext = dec_sign_ext
                   ? {{(XLEN-16){bus.imm[15]}}, bus.imm}
                   : {{(XLEN-16){1'b0}}, bus.imm};
    assign dst     = dec_rd_sel ? bus.rd_addr : bus.rt_addr;

    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        store_d   = store_q;
        if (bus.flush || (!bus.stall && (!bus.in_valid || dec_illegal))) begin
            valid_d   = 1'b0;
            illegal_d = !bus.flush && bus.in_valid && dec_illegal;
            ctrl_d    = '0;
            wr_en_d   = 1'b0;
            wr_addr_d = '0;
            alu_a_d   = '0;
            alu_b_d   = '0;
            store_d   = '0;
        end else if (!bus.stall) begin
            valid_d   = 1'b1;
            illegal_d = 1'b0;
            ctrl_d    = dec_ctrl;
            wr_en_d   = dec_wr_en && (dst != 5'd0);
            wr_addr_d = dst;
            alu_a_d   = rs_val;
            alu_b_d   = dec_imm_sel ? imm_ext : rt_val;
            store_d   = rt_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            store_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            store_q   <= store_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.illegal    = illegal_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.store_data = store_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences
// for stall, flush, illegal hold and asynchronous reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN = 32;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        in_valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic        exm_wr_en;
        logic [4:0]  exm_wr_addr;
        logic [31:0] exm_result;
        logic        mwb_wr_en;
        logic [4:0]  mwb_wr_addr;
        logic [31:0] mwb_result;
    } vin_t;

    typedef struct packed {
        logic        out_valid;
        logic        illegal;
        logic [3:0]  alu_ctrl;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [31:0] store_data;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t  vecs[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    vin_t  vi;
    vout_t zero_o;
    vout_t slt_o;
    vout_t add_o;
    vout_t ill_o;

    function automatic vin_t mkin(
        input logic [5:0]  op,
        input logic [5:0]  fn,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [15:0] im,
        input logic [4:0]  rsa,
        input logic [4:0]  rta,
        input logic [4:0]  rda
    );
        vin_t v;
        v          = '0;
        v.in_valid = 1'b1;
        v.opcode   = op;
        v.funct    = fn;
        v.rs_data  = rs;
        v.rt_data  = rt;
        v.imm      = im;
        v.rs_addr  = rsa;
        v.rt_addr  = rta;
        v.rd_addr  = rda;
        return v;
    endfunction

    function automatic vout_t mkout(
        input logic        ov,
        input logic        ill,
        input logic [3:0]  ctrl,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] sd
    );
        vout_t o;
        o.out_valid  = ov;
        o.illegal    = ill;
        o.alu_ctrl   = ctrl;
        o.wr_en      = we;
        o.wr_addr    = wa;
        o.alu_a      = a;
        o.alu_b      = b;
        o.store_data = sd;
        return o;
    endfunction

    task automatic add(input vin_t v, input vout_t o);
        vec_t e;
        e.i = v;
        e.o = o;
        vecs.push_back(e);
    endtask

    task automatic drive(input vin_t v);
        bus.in_valid    = v.in_valid;
        bus.opcode      = v.opcode;
        bus.funct       = v.funct;
        bus.rs_data     = v.rs_data;
        bus.rt_data     = v.rt_data;
        bus.imm         = v.imm;
        bus.rs_addr     = v.rs_addr;
        bus.rt_addr     = v.rt_addr;
        bus.rd_addr     = v.rd_addr;
        bus.exm_wr_en   = v.exm_wr_en;
        bus.exm_wr_addr = v.exm_wr_addr;
        bus.exm_result  = v.exm_result;
        bus.mwb_wr_en   = v.mwb_wr_en;
        bus.mwb_wr_addr = v.mwb_wr_addr;
        bus.mwb_result  = v.mwb_result;
    endtask

    task automatic check(input string tag, input vout_t e);
        vout_t a;
        a = mkout(bus.out_valid, bus.illegal, bus.alu_ctrl, bus.wr_en,
                  bus.wr_addr, bus.alu_a, bus.alu_b, bus.store_data);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got v=%b il=%b c=%h we=%b wa=%0d a=%h b=%h sd=%h want v=%b il=%b c=%h we=%b wa=%0d a=%h b=%h sd=%h",
                     tag, a.out_valid, a.illegal, a.alu_ctrl, a.wr_en,
                     a.wr_addr, a.alu_a, a.alu_b, a.store_data,
                     e.out_valid, e.illegal, e.alu_ctrl, e.wr_en,
                     e.wr_addr, e.alu_a, e.alu_b, e.store_data);
        end
    endtask

    task automatic step_check(input string tag, input vout_t e);
        @(posedge clk);
        #1;
        check(tag, e);
    endtask

    initial begin
        zero_o = '0;
        drive('0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        rst_n     = 1'b0;

        // R-type and I-type decode, register-file operands
        add(mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3),
            mkout(1, 0, 4'b0010, 1, 5'd3, 32'd5, 32'd7, 32'd7));
        add(mkin(6'h08, 6'h00, 32'd10, 32'h33, 16'hFFFF, 5'd1, 5'd9, 5'd0),
            mkout(1, 0, 4'b0010, 1, 5'd9, 32'd10, 32'hFFFF_FFFF, 32'h33));
        add(mkin(6'h0D, 6'h00, 32'd10, 32'h33, 16'hFFFF, 5'd1, 5'd9, 5'd0),
            mkout(1, 0, 4'b0001, 1, 5'd9, 32'd10, 32'h0000_FFFF, 32'h33));
        add(mkin(6'h0C, 6'h00, 32'hF0, 32'h1, 16'h8001, 5'd2, 5'd4, 5'd0),
            mkout(1, 0, 4'b0000, 1, 5'd4, 32'hF0, 32'h0000_8001, 32'h1));
        add(mkin(6'h0E, 6'h00, 32'hF0, 32'h1, 16'hA5A5, 5'd2, 5'd4, 5'd0),
            mkout(1, 0, 4'b0011, 1, 5'd4, 32'hF0, 32'h0000_A5A5, 32'h1));
        add(mkin(6'h0A, 6'h00, 32'd3, 32'h2, 16'h8000, 5'd2, 5'd6, 5'd0),
            mkout(1, 0, 4'b1011, 1, 5'd6, 32'd3, 32'hFFFF_8000, 32'h2));
        add(mkin(6'h23, 6'h00, 32'h100, 32'h2, 16'h0004, 5'd2, 5'd7, 5'd0),
            mkout(1, 0, 4'b0010, 1, 5'd7, 32'h100, 32'h4, 32'h2));
        add(mkin(6'h2B, 6'h00, 32'h100, 32'h1234, 16'hFFFC, 5'd2, 5'd8, 5'd0),
            mkout(1, 0, 4'b0010, 0, 5'd8, 32'h100, 32'hFFFF_FFFC, 32'h1234));
        add(mkin(6'h00, 6'h24, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd10),
            mkout(1, 0, 4'b0000, 1, 5'd10, 32'd1, 32'd2, 32'd2));
        add(mkin(6'h00, 6'h25, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd11),
            mkout(1, 0, 4'b0001, 1, 5'd11, 32'd1, 32'd2, 32'd2));
        add(mkin(6'h00, 6'h26, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd12),
            mkout(1, 0, 4'b0011, 1, 5'd12, 32'd1, 32'd2, 32'd2));
        add(mkin(6'h00, 6'h22, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd13),
            mkout(1, 0, 4'b1010, 1, 5'd13, 32'd1, 32'd2, 32'd2));
        add(mkin(6'h00, 6'h2A, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd31),
            mkout(1, 0, 4'b1011, 1, 5'd31, 32'd1, 32'd2, 32'd2));
        // rd=0 keeps out_valid but suppresses the write
        add(mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd0),
            mkout(1, 0, 4'b0010, 0, 5'd0, 32'd5, 32'd7, 32'd7));
        add(mkin(6'h00, 6'h21, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3),
            mkout(0, 1, 4'b0000, 0, 5'd0, 32'd0, 32'd0, 32'd0));
        add(mkin(6'h3F, 6'h20, 32'd5, 32'd7, 16'h1, 5'd1, 5'd2, 5'd3),
            mkout(0, 1, 4'b0000, 0, 5'd0, 32'd0, 32'd0, 32'd0));
        vi = mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3);
        vi.in_valid = 1'b0;
        add(vi, zero_o);

        // Forwarding: EX/MEM over MEM/WB on rs
        vi = mkin(6'h00, 6'h22, 32'd11, 32'd3, 16'h0, 5'd4, 5'd6, 5'd2);
        vi.exm_wr_en = 1; vi.exm_wr_addr = 5'd4; vi.exm_result = 32'd99;
        vi.mwb_wr_en = 1; vi.mwb_wr_addr = 5'd4; vi.mwb_result = 32'd55;
        add(vi, mkout(1, 0, 4'b1010, 1, 5'd2,
                      FWD ? 32'd99 : 32'd11, 32'd3, 32'd3));
        // MEM/WB only on rt, disabled EX/MEM ignored
        vi = mkin(6'h00, 6'h20, 32'd20, 32'd3, 16'h0, 5'd1, 5'd6, 5'd7);
        vi.exm_wr_en = 0; vi.exm_wr_addr = 5'd6; vi.exm_result = 32'd99;
        vi.mwb_wr_en = 1; vi.mwb_wr_addr = 5'd6; vi.mwb_result = 32'd77;
        add(vi, mkout(1, 0, 4'b0010, 1, 5'd7, 32'd20,
                      FWD ? 32'd77 : 32'd3, FWD ? 32'd77 : 32'd3));
        // Register 0 is never forwarded
        vi = mkin(6'h00, 6'h20, 32'd8, 32'd1, 16'h0, 5'd0, 5'd2, 5'd9);
        vi.exm_wr_en = 1; vi.exm_wr_addr = 5'd0; vi.exm_result = 32'd99;
        vi.mwb_wr_en = 1; vi.mwb_wr_addr = 5'd0; vi.mwb_result = 32'd55;
        add(vi, mkout(1, 0, 4'b0010, 1, 5'd9, 32'd8, 32'd1, 32'd1));
        // SW store data takes the forwarded rt
        vi = mkin(6'h2B, 6'h00, 32'h100, 32'h1234, 16'h0008, 5'd2, 5'd8, 5'd0);
        vi.exm_wr_en = 1; vi.exm_wr_addr = 5'd8; vi.exm_result = 32'd99;
        add(vi, mkout(1, 0, 4'b0010, 0, 5'd8, 32'h100, 32'h8,
                      FWD ? 32'd99 : 32'h1234));

        #12;
        check("reset", zero_o);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            step_check($sformatf("vec%0d", k), vecs[k].o);
        end

        // Stall holds SLT for three cycles, then stall+flush bubbles
        slt_o = mkout(1, 0, 4'b1011, 1, 5'd5, 32'd3, 32'd9, 32'd9);
        @(negedge clk);
        drive(mkin(6'h00, 6'h2A, 32'd3, 32'd9, 16'h0, 5'd1, 5'd2, 5'd5));
        step_check("slt", slt_o);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(mkin(6'h00, 6'h20, 32'd40 + c, 32'd50, 16'h0,
                       5'd1, 5'd2, 5'd6));
            bus.stall = 1'b1;
            step_check($sformatf("stall%0d", c), slt_o);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        step_check("stall_flush", zero_o);

        // Flush alone over a valid instruction
        @(negedge clk);
        bus.stall = 1'b0;
        drive(mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3));
        step_check("flush", zero_o);
        bus.flush = 1'b0;

        // Illegal pulse holds under stall, then clears
        ill_o = mkout(0, 1, 4'b0000, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        drive(mkin(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd3));
        step_check("ill", ill_o);
        @(negedge clk);
        drive(mkin(6'h00, 6'h20, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd3));
        bus.stall = 1'b1;
        step_check("ill_stall", ill_o);
        @(negedge clk);
        bus.stall = 1'b0;
        drive('0);
        step_check("ill_clear", zero_o);

        // Asynchronous reset mid-cycle, then clean resume
        add_o = mkout(1, 0, 4'b0010, 1, 5'd3, 32'd5, 32'd7, 32'd7);
        @(negedge clk);
        drive(mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3));
        step_check("pre_rst", add_o);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", zero_o);
        @(negedge clk);
        drive('0);
        rst_n = 1'b1;
        step_check("post_rst", zero_o);
        @(negedge clk);
        drive(mkin(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3));
        step_check("resume", add_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
